// File: rtl/softex_tcdm_splitter.sv
// Splits one wide TCDM access into MP 64-bit narrow accesses and re-aligns the
// per-port read responses into a single wide response through per-port FIFOs.
module softex_tcdm_splitter #(
  parameter int unsigned MP         = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              in_req_i,
  output logic              in_gnt_o,
  input  logic [31:0]       in_add_i,
  input  logic              in_wen_i,
  input  logic [MP*8-1:0]   in_be_i,
  input  logic [MP*64-1:0]  in_data_i,
  output logic              in_r_valid_o,
  input  logic              in_r_ready_i,
  output logic [MP*64-1:0]  in_r_data_o,
  output logic [MP-1:0]     out_req_o,
  input  logic [MP-1:0]     out_gnt_i,
  output logic [MP*32-1:0]  out_add_o,
  output logic [MP-1:0]     out_wen_o,
  output logic [MP*8-1:0]   out_be_o,
  output logic [MP*64-1:0]  out_data_o,
  input  logic [MP-1:0]     out_r_valid_i,
  input  logic [MP*64-1:0]  out_r_data_i,
  output logic              err_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [MP-1:0] r_done;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic          w_stall;
  logic          w_pop;
  logic [MP-1:0] w_port_ok;
  logic [MP-1:0] w_nonempty;
  logic [MP-1:0] w_ovf;

  // Reads stall once every FIFO slot is already reserved by an outstanding read.
  assign w_stall      = in_wen_i & (r_cnt == CW'(FIFO_DEPTH));
  assign in_gnt_o     = in_req_i & (&w_port_ok);
  assign in_r_valid_o = &w_nonempty;
  assign w_pop        = in_r_valid_o & in_r_ready_i;
  assign err_o        = r_err;

  for (genvar g = 0; g < MP; g++) begin : g_port
    logic [63:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_fcnt;
    logic          w_full;
    logic          w_push;

    assign out_add_o[32*g +: 32]  = in_add_i + 32'(8 * g);
    assign out_be_o[8*g +: 8]     = in_be_i[8*g +: 8];
    assign out_data_o[64*g +: 64] = in_data_i[64*g +: 64];
    assign out_wen_o[g]           = in_wen_i;
    assign out_req_o[g]           = in_req_i & ~r_done[g] & ~w_stall;
    assign w_port_ok[g]           = r_done[g] | (out_req_o[g] & out_gnt_i[g]);

    assign w_full        = (r_fcnt == CW'(FIFO_DEPTH));
    assign w_nonempty[g] = (r_fcnt != '0);
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign w_push        = out_r_valid_i[g] & (~w_full | w_pop);
    assign w_ovf[g]      = out_r_valid_i[g] & w_full & ~w_pop;
    assign in_r_data_o[64*g +: 64] = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= out_r_data_i[64*g +: 64];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_fcnt <= '0;
      end else if (clear_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_fcnt <= '0;
      end else begin
        if (w_push) r_wptr <= (r_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
        if (w_pop)  r_rptr <= (r_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_fcnt <= r_fcnt + 1'b1;
          2'b01:   r_fcnt <= r_fcnt - 1'b1;
          default: r_fcnt <= r_fcnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (clear_i) begin
      r_done <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (in_gnt_o) r_done <= '0;
      else          r_done <= r_done | (out_req_o & out_gnt_i);
      case ({in_gnt_o & in_wen_i, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (|w_ovf) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_softex_tcdm_splitter.sv
// Directed bench for softex_tcdm_splitter (MP=2, FIFO_DEPTH=2); wide read
// responses are checked by a scoreboard monitor, control signals inline.
module tb_softex_tcdm_splitter;
  localparam int MP = 2;
  localparam int FD = 2;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           clear_i;
  logic           in_req_i;
  logic           in_gnt_o;
  logic [31:0]    in_add_i;
  logic           in_wen_i;
  logic [15:0]    in_be_i;
  logic [127:0]   in_data_i;
  logic           in_r_valid_o;
  logic           in_r_ready_i;
  logic [127:0]   in_r_data_o;
  logic [1:0]     out_req_o;
  logic [1:0]     out_gnt_i;
  logic [63:0]    out_add_o;
  logic [1:0]     out_wen_o;
  logic [15:0]    out_be_o;
  logic [127:0]   out_data_o;
  logic [1:0]     out_r_valid_i;
  logic [127:0]   out_r_data_i;
  logic           err_o;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];

  softex_tcdm_splitter #(.MP(MP), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i),
    .in_wen_i(in_wen_i), .in_be_i(in_be_i), .in_data_i(in_data_i),
    .in_r_valid_o(in_r_valid_o), .in_r_ready_i(in_r_ready_i),
    .in_r_data_o(in_r_data_o), .out_req_o(out_req_o), .out_gnt_i(out_gnt_i),
    .out_add_o(out_add_o), .out_wen_o(out_wen_o), .out_be_o(out_be_o),
    .out_data_o(out_data_o), .out_r_valid_i(out_r_valid_i),
    .out_r_data_i(out_r_data_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic issue(input logic [31:0] add, input logic wen, input logic [1:0] gnt);
    in_req_i  = 1'b1;
    in_add_i  = add;
    in_wen_i  = wen;
    out_gnt_i = gnt;
  endtask

  task automatic respond(input logic [1:0] v, input logic [127:0] d);
    out_r_valid_i = v;
    out_r_data_i  = d;
  endtask

  // Scoreboard monitor: every accepted wide response must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && in_r_valid_o === 1'b1 && in_r_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %0h expected none", in_r_data_o);
      end else begin
        check("rsp_data", in_r_data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; in_req_i = 1'b0; in_add_i = '0; in_wen_i = 1'b0;
    in_be_i = 16'hFFFF; in_data_i = '0; in_r_ready_i = 1'b1; out_gnt_i = '0;
    out_r_valid_i = '0; out_r_data_i = '0;
    smp();
    check("rst_req", out_req_o, 2'b00);
    check("rst_gnt", in_gnt_o, 1'b0);
    check("rst_rvalid", in_r_valid_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    step(); rst_ni = 1'b1;

    // Single-cycle read, both ports grant together
    step(); issue(32'h1000, 1'b1, 2'b11);
    smp();
    check("t1_gnt", in_gnt_o, 1'b1);
    check("t1_add", out_add_o, {32'h1008, 32'h1000});
    check("t1_req", out_req_o, 2'b11);
    step(); in_req_i = 1'b0; out_gnt_i = 2'b00;
    respond(2'b11, {64'h22, 64'h11}); exp_q.push_back({64'h22, 64'h11});
    step(); respond(2'b00, '0);
    step();

    // Staggered grants: port 0 first, port 1 three cycles later
    step(); issue(32'h2000, 1'b1, 2'b01); in_be_i = 16'hF00F;
    smp();
    check("t2_req_c1", out_req_o, 2'b11);
    check("t2_gnt_c1", in_gnt_o, 1'b0);
    check("t2_be", out_be_o, {8'hF0, 8'h0F});
    step(); out_gnt_i = 2'b00;
    smp(); check("t2_req_c2", out_req_o, 2'b10); check("t2_gnt_c2", in_gnt_o, 1'b0);
    step();
    smp(); check("t2_req_c3", out_req_o, 2'b10); check("t2_gnt_c3", in_gnt_o, 1'b0);
    step(); out_gnt_i = 2'b10;
    smp(); check("t2_req_c4", out_req_o, 2'b10); check("t2_gnt_c4", in_gnt_o, 1'b1);
    // Skewed responses: port 0 at t, port 1 at t+2
    step(); in_req_i = 1'b0; out_gnt_i = 2'b00; in_be_i = 16'hFFFF;
    respond(2'b01, {64'h0, 64'hA}); exp_q.push_back({64'hB, 64'hA});
    step(); respond(2'b00, '0);
    step(); respond(2'b10, {64'hB, 64'h0});
    smp(); check("t2_rvalid_t2", in_r_valid_o, 1'b0);
    step(); respond(2'b00, '0);
    smp(); check("t2_rvalid_t3", in_r_valid_o, 1'b1);
    step();
    smp(); check("t2_rvalid_after", in_r_valid_o, 1'b0);

    // Outstanding-read limit with the response path stalled
    step(); in_r_ready_i = 1'b0; issue(32'h3000, 1'b1, 2'b11);
    smp(); check("t3_gnt_a", in_gnt_o, 1'b1);
    step(); issue(32'h3010, 1'b1, 2'b11);
    respond(2'b11, {64'hA1, 64'hA0}); exp_q.push_back({64'hA1, 64'hA0});
    smp(); check("t3_gnt_b", in_gnt_o, 1'b1);
    step(); issue(32'h3020, 1'b1, 2'b11);
    respond(2'b11, {64'hB1, 64'hB0}); exp_q.push_back({64'hB1, 64'hB0});
    smp(); check("t3_gnt_c_held", in_gnt_o, 1'b0); check("t3_req_c_held", out_req_o, 2'b00);
    step(); respond(2'b00, '0);
    smp();
    check("t3_req_c_held2", out_req_o, 2'b00);
    check("t3_rvalid", in_r_valid_o, 1'b1);
    // Pop while both FIFOs are full and push again in the same cycle
    step(); in_r_ready_i = 1'b1;
    respond(2'b11, {64'hC1, 64'hC0}); exp_q.push_back({64'hC1, 64'hC0});
    smp(); check("t3_req_popcyc", out_req_o, 2'b00); check("t3_gnt_popcyc", in_gnt_o, 1'b0);
    step(); in_r_ready_i = 1'b0; respond(2'b00, '0);
    smp();
    check("t3_req_c", out_req_o, 2'b11);
    check("t3_gnt_c", in_gnt_o, 1'b1);
    check("t3_err", err_o, 1'b0);
    step(); in_req_i = 1'b0; out_gnt_i = 2'b00; in_r_ready_i = 1'b1;
    step(); step(); step();
    smp(); check("t3_drained", in_r_valid_o, 1'b0);

    // Write: granted, no wide response
    step(); issue(32'h4000, 1'b0, 2'b11);
    in_data_i = {64'hDEAD_BEEF_0000_0002, 64'hCAFE_F00D_0000_0001};
    smp();
    check("t4_gnt", in_gnt_o, 1'b1);
    check("t4_wen", out_wen_o, 2'b00);
    check("t4_data", out_data_o, {64'hDEAD_BEEF_0000_0002, 64'hCAFE_F00D_0000_0001});
    step(); in_req_i = 1'b0; out_gnt_i = 2'b00;
    step();
    smp(); check("t4_no_rsp", in_r_valid_o, 1'b0);

    // Overflow of FIFO 0, then soft clear
    step(); in_r_ready_i = 1'b0; issue(32'h5000, 1'b1, 2'b11);
    smp(); check("t5_gnt_d", in_gnt_o, 1'b1);
    step(); in_req_i = 1'b0; out_gnt_i = 2'b00; respond(2'b01, 128'h1);
    step(); respond(2'b01, 128'h2);
    smp(); check("t5_err_1", err_o, 1'b0);
    step(); respond(2'b01, 128'h3);
    smp(); check("t5_err_2", err_o, 1'b0);
    step(); respond(2'b00, '0);
    smp(); check("t5_err_set", err_o, 1'b1);
    step(); step();
    smp(); check("t5_err_hold", err_o, 1'b1); check("t5_rvalid", in_r_valid_o, 1'b0);
    step(); clear_i = 1'b1;
    step(); clear_i = 1'b0;
    smp(); check("t5_err_clr", err_o, 1'b0); check("t5_rvalid_clr", in_r_valid_o, 1'b0);
    step(); respond(2'b10, {64'h77, 64'h0});
    step(); respond(2'b00, '0);
    smp(); check("t5_fifo0_empty", in_r_valid_o, 1'b0);
    // Counter was cleared: two reads fit, the third stalls
    step(); issue(32'h6000, 1'b1, 2'b11);
    smp(); check("t5_gnt_e", in_gnt_o, 1'b1);
    step(); issue(32'h6010, 1'b1, 2'b11);
    smp(); check("t5_gnt_f", in_gnt_o, 1'b1);
    step(); issue(32'h6020, 1'b1, 2'b11);
    smp(); check("t5_gnt_g", in_gnt_o, 1'b0); check("t5_req_g", out_req_o, 2'b00);
    step(); in_req_i = 1'b0; out_gnt_i = 2'b00;
    step();

    check("sb_empty", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/softex_tcdm_splitter.md
SOFTEX_TCDM_SPLITTER -- requirements
Module: softex_tcdm_splitter

Interface
REQ-001 SHALL have parameter MP, default 2: number of 64-bit narrow TCDM ports (MP >= 1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: per-port response FIFO depth and maximum outstanding wide reads (>= 1).
REQ-003 SHALL have ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear
- in_req_i  in  1  wide request valid
- in_gnt_o  out  1  wide request grant
- in_add_i  in  32  wide byte address, 8-byte aligned
- in_wen_i  in  1  1 = read, 0 = write
- in_be_i  in  MP*8  wide byte enables
- in_data_i  in  MP*64  wide write data
- in_r_valid_o  out  1  wide read response valid
- in_r_ready_i  in  1  wide read response ready
- in_r_data_o  out  MP*64  wide read data, port 0 in bits [63:0]
- out_req_o  out  MP  narrow request, per port
- out_gnt_i  in  MP  narrow grant, per port
- out_add_o  out  MP*32  narrow address, per port
- out_wen_o  out  MP  narrow read/write, per port
- out_be_o  out  MP*8  narrow byte enables, per port
- out_data_o  out  MP*64  narrow write data, per port
- out_r_valid_i  in  MP  narrow read response valid, fixed latency, no backpressure
- out_r_data_i  in  MP*64  narrow read data, per port
- err_o  out  1  sticky FIFO overflow/underflow flag

Function
REQ-004 SHALL drive out_add_o[i] = in_add_i + 8*i, out_be_o[i] = in_be_i[8i+:8], out_data_o[i] = in_data_i[64i+:64], out_wen_o[i] = in_wen_i, combinationally.
REQ-005 SHALL keep one done[i] flag per port; done[i] is set on the edge where out_req_o[i] & out_gnt_i[i].
REQ-006 SHALL drive out_req_o[i] = in_req_i & ~done[i] & ~stall, where stall = in_wen_i & (cnt == FIFO_DEPTH).
REQ-007 SHALL assert in_gnt_o = in_req_i & AND over i of (done[i] | (out_req_o[i] & out_gnt_i[i])), so grant is zero-latency when all ports grant in the same cycle.
REQ-008 SHALL clear all done[i] on the edge where in_gnt_o is high, so no port is re-requested for the same transaction.
REQ-009 SHALL rely on upstream holding in_add_i/in_wen_i/in_be_i/in_data_i stable while in_req_i & ~in_gnt_o; deasserting in_req_i before grant is a protocol violation and leaves done[] unchanged.
REQ-010 SHALL keep outstanding-read counter cnt (0..FIFO_DEPTH): +1 on in_gnt_o & in_wen_i, -1 on pop (in_r_valid_o & in_r_ready_i), unchanged when both occur in the same cycle.
REQ-011 SHALL push out_r_data_i[i] into FIFO i whenever out_r_valid_i[i], independently per port.
REQ-012 SHALL assert in_r_valid_o only when all MP FIFOs are non-empty, present their heads concatenated on in_r_data_o, and pop all FIFOs together on in_r_valid_o & in_r_ready_i.
REQ-013 SHALL allow a push and a pop on the same FIFO in the same cycle, including when it is full, with no data loss.
REQ-014 SHALL set err_o on a push into a full FIFO without a simultaneous pop, and SHALL drop the pushed data; err_o holds until reset or clear_i.
REQ-015 SHALL generate no wide response for writes; writes do not change cnt.
REQ-016 clear_i SHALL, on the next edge, zero done[], cnt, all FIFO pointers and err_o; clear_i has priority over all same-cycle updates.

Reset
REQ-017 While rst_ni is low, SHALL hold done[]=0, cnt=0, all FIFOs empty and err_o=0; hence out_req_o=0, in_gnt_o=0 and in_r_valid_o=0.
REQ-018 SHALL drop any in-flight transaction on reset; late out_r_valid_i after reset release is pushed normally and is the bench's responsibility to avoid.

Verification
REQ-019 MP=2, read at 0x1000, both out_gnt_i high same cycle -> in_gnt_o same cycle; out_add_o = 0x1000/0x1008; cnt becomes 1.
REQ-020 Port 0 granted cycle 1, port 1 granted cycle 4 -> out_req_o[0] low from cycle 2; in_gnt_o high only in cycle 4.
REQ-021 out_r_valid_i[0] with 0xA at t, out_r_valid_i[1] with 0xB at t+2, in_r_ready_i=1 -> in_r_valid_o first at t+3 with in_r_data_o = {0xB,0xA}.
REQ-022 FIFO_DEPTH=2, three reads, in_r_ready_i=0 -> first two granted, third held with out_req_o=0 until one pop, then granted.
REQ-023 Write, all grants -> in_gnt_o high, cnt stays 0, in_r_valid_o stays 0.
REQ-024 Force out_r_valid_i[0] three times with FIFO 0 full, no pop -> err_o high and stays high; clear_i -> err_o=0, cnt=0, in_r_valid_o=0.
